// File: rtl/partsel_down_unpacker.sv
// -----------------------------------------------------------------------------
// partsel_down_unpacker
//
// Purpose:
//   Takes one packed word and hands it out as N/FW fields of FW bits each, one
//   field per output handshake. The leftmost field (the one containing index
//   MSB) goes out first. Each field is read with an indexed descending
//   part-select, buffer[ptr -: FW], where ptr is a signed pointer register.
//   This block is the read-side counterpart of a variable-offset '+:' write
//   path. It exercises '-:' selects on descending, ascending and negative-index
//   word ranges.
//
// Parameters:
//   MSB, LSB : declared word range [MSB:LSB]. MSB < LSB gives an ascending
//              (big-endian) range. Either index may be negative.
//   FW       : field width. N = |MSB-LSB|+1 must be a multiple of FW.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   a word is offered on in_data
//   in_ready   the unpacker accepts a word this cycle
//   in_data    packed word, declared [MSB:LSB]
//   out_valid  out_field holds a valid field
//   out_ready  the consumer takes out_field this cycle
//   out_field  current field; out_field[FW-1] is the bit nearest MSB
//   out_idx    index k of the current field, 0 = leftmost
//   out_last   the current field is the final one, k = N/FW-1
// -----------------------------------------------------------------------------
module partsel_down_unpacker #(
  parameter int MSB = 7,
  parameter int LSB = 0,
  parameter int FW  = 2,
  // Derived values. These are not meant to be overridden.
  parameter int N   = (MSB >= LSB) ? (MSB - LSB + 1) : (LSB - MSB + 1),
  parameter int NF  = N / FW,
  parameter int IW  = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MSB:LSB]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FW-1:0]   out_field,
  output logic [IW-1:0]   out_idx,
  output logic            out_last
);

  // The word must split into whole fields.
  if ((N % FW) != 0) begin : g_bad_width
    $error("partsel_down_unpacker: word width %0d is not a multiple of FW=%0d", N, FW);
  end

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  localparam bit DESC = (MSB >= LSB);

  // A 32-bit signed pointer covers MSB +/- N for any practical word.
  localparam int PW = 32;

  // Field 0 always holds index MSB in its top bit. For a descending range the
  // '-:' base is MSB itself. For an ascending range the base is the far end
  // of the field, so that the select [base-FW+1 : base] starts at MSB.
  localparam logic signed [PW-1:0] PTR0 = DESC ? PW'(MSB) : PW'(MSB + FW - 1);
  localparam logic signed [PW-1:0] STEP = DESC ? -PW'(FW) : PW'(FW);

  localparam int LO = (MSB < LSB) ? MSB : LSB;
  localparam int HI = (MSB < LSB) ? LSB : MSB;

  localparam logic [IW-1:0] K_LAST = IW'(NF - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]             state;
  logic [MSB:LSB]         buffer;
  logic signed [PW-1:0]   ptr;
  logic [IW-1:0]          k;

  logic                   in_accept;
  logic                   emit;

  assign emit      = (state == EMIT);
  assign out_valid = emit;
  assign out_idx   = k;
  assign out_last  = emit && (k == K_LAST);

  // A new word may be taken in the same cycle the last field leaves. This
  // keeps back-to-back words free of idle cycles.
  assign in_ready  = (state == IDLE) || (out_last && out_ready);
  assign in_accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  // NOTE: give every always_comb output a default first. A path that does not
  //       assign the output would otherwise infer a latch.
  always_comb begin
    out_field = '0;
    // In IDLE the pointer is not kept in range, so the select is used only in
    // EMIT. Reset therefore reads back as an all-zero field.
    if (emit) begin
      out_field = buffer[ptr -: FW];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing
  // ---------------------------------------------------------------------------
  // NOTE: use non-blocking assignments for every register here. Blocking
  //       assignments would let later statements see this cycle's new values
  //       and would race with other clocked processes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      // NOTE: the word buffer is a register, not a memory array, so it is
      //       cheap to clear. Clearing it gives a defined value after reset.
      buffer <= '0;
      ptr    <= '0;
      k      <= '0;
    end else if (in_accept) begin
      state  <= EMIT;
      buffer <= in_data;
      ptr    <= PTR0;
      k      <= '0;
    end else if (emit && out_ready) begin
      if (out_last) begin
        state <= IDLE;
        ptr   <= '0;
        k     <= '0;
      end else begin
        ptr <= ptr + STEP;
        k   <= k + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // The pointer must never select outside the declared range while a field is
  // being presented.
  // ---------------------------------------------------------------------------
  ptr_in_range : assert property (
    @(posedge clk) disable iff (!rst_n)
      emit |-> ((ptr - PW'(FW) + 1 >= PW'(LO)) && (ptr <= PW'(HI)))
  );

endmodule
